tl_xbar_nm: RTL and testbench
=============================

// Module: tl_xbar_nm
// PURPOSE
//  N-master to 1-slave TileLink-UL crossbar, successor to the single-master passthrough xbar.
//  - Channel A: round-robin arbitration across N masters; master index prepended to a_source.
//  - Channel D: responses routed back by that index; per-master outstanding limit enforced.
//  - Sits between core-side masters and the CDC adapter; slave-side ports face the adapter.
// PARAMETERS
//  N_MASTERS       2   number of master ports (>=2)
//  ADDR_WIDTH      32  address width
//  DATA_WIDTH      32  data width; MASK_WIDTH = DATA_WIDTH/8
//  SIZE_WIDTH      3   a_size/d_size width
//  OPCODE_WIDTH    3   opcode width
//  PARAM_WIDTH     3   param width
//  SRC_WIDTH       1   per-master source width
//  MAX_OUTSTANDING 4   max in-flight requests per master (>=1)
//  Derived: IDX_W = max(1,$clog2(N_MASTERS)); OSRC_W = IDX_W+SRC_WIDTH; CNT_W = $clog2(MAX_OUTSTANDING+1)
// PORTS
//  clk            in   1              clock
//  reset          in   1              asynchronous, active-high reset
//  m_a_valid      in   N              per-master A valid
//  m_a_ready      out  N              per-master A ready
//  m_a_opcode/param/size/source/address/mask/data  in  N*field  packed, master i at slice i
//  m_d_valid      out  N              per-master D valid
//  m_d_ready      in   N              per-master D ready
//  m_d_opcode/param/size/source/sink/data/error    out N*field  packed (broadcast, qualified by m_d_valid)
//  a_valid_out    out  1              slave-side A valid
//  a_ready_out    in   1              slave-side A ready
//  a_*_out        out  field          opcode/param/size/address/mask/data; a_source_out is OSRC_W
//  d_valid_in     in   1              slave-side D valid
//  d_ready_in     out  1              slave-side D ready
//  d_*_in         in   field          opcode/param/size/sink/data/error; d_source_in is OSRC_W
//  err_unmapped   out  1              sticky: D response carried index >= N_MASTERS
// BEHAVIOUR
//  Reset: all valids/readies 0, rr_ptr=0, lock=0, all counters 0, err_unmapped=0.
//  Eligible(i) = m_a_valid[i] && cnt[i] < MAX_OUTSTANDING.
//  Arbitration: when lock=0, grant first eligible master at or after rr_ptr (cyclic); combinational.
//  a_valid_out = any grant; A fields muxed from granted master; a_source_out = {idx, m_a_source[idx]}.
//  m_a_ready[i] = grant[i] && a_ready_out; non-granted masters see ready=0.
//  Lock: if a_valid_out && !a_ready_out, lock=1 and the grant is held; A payload stays stable until handshake.
//  On A handshake: lock<=0, rr_ptr<=(idx+1) mod N, cnt[idx]++.
//  Zero-cycle latency A and D (no storage) unless TL_XBAR_REG_SLICE_EN is defined.
//  D routing: idx=d_source_in[OSRC_W-1:SRC_WIDTH]; m_d_valid[idx]=d_valid_in; d_ready_in=m_d_ready[idx].
//  m_d_source = d_source_in low SRC_WIDTH bits; other D fields broadcast to all masters.
//  On D handshake to idx: cnt[idx]--. Same-cycle A and D handshake on one master: cnt unchanged.
//  Unmapped idx (>=N_MASTERS, non-power-of-2 N): d_ready_in=1, response dropped, err_unmapped<=1.
//  Counter at MAX_OUTSTANDING: master masked from arbitration until a D response frees a slot.
//  Counter at 0 with D arriving: no underflow (saturate at 0) and set err_unmapped.
//  Reset mid-transfer: all in-flight state discarded; masters must re-issue.
// CONFIGURATION
//  TL_XBAR_REG_SLICE_EN defined: 2-entry skid buffer on slave-side A; full throughput.
//  - With it: +1 cycle A latency; a_ready_out does not combinationally reach m_a_ready.
//  - Arbiter advances on enqueue into the slice; counters increment on enqueue.
//  Undefined: slave-side A driven combinationally from the arbiter mux as described above.
// STRUCTURE
//  Package tl_pkg: TL-UL opcode constants (Get=4, PutFullData=0, PutPartialData=1, AccessAck=0,
//  AccessAckData=1) and default width localparams.
//  Sub-module tl_rr_arbiter: N-way round-robin with hold/lock input; one instance for channel A.
//  Skid buffer is inline under the macro; counters are a generate loop in the top module.
// TESTING
//  1. N=2, both masters valid every cycle, a_ready_out=1 -> grants alternate 0,1,0,1; a_source_out MSB alternates.
//  2. M0 valid, a_ready_out=0 for 3 cycles while M1 raises valid -> grant stays M0, payload stable; M1 granted next.
//  3. MAX_OUTSTANDING=2, M0 issues 2 Gets, no D -> m_a_ready[0]=0; one AccessAckData to idx 0 -> M0 eligible again.
//  4. d_source_in={1,0}, m_d_ready[1]=0 for 2 cycles -> d_ready_in=0, m_d_valid=2'b10 held; handshake decrements cnt[1].
//  5. N=3, d_source_in idx=3 -> d_ready_in=1, no m_d_valid, err_unmapped=1 and sticky until reset.
//  6. Assert reset with lock=1 and cnt=2 -> next cycle all valids 0, cnt 0, rr_ptr 0; with REG_SLICE_EN, slice empty.

Source files
------------

// File: rtl/tl_pkg.sv
// tl_pkg: TileLink-UL opcode constants and default field widths shared by the crossbar files
package tl_pkg;
  localparam logic [2:0] TL_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] TL_GET              = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA  = 3'd1;
  localparam int TL_AW    = 32;
  localparam int TL_DW    = 32;
  localparam int TL_SZW   = 3;
  localparam int TL_OPW   = 3;
  localparam int TL_PW    = 3;
  localparam int TL_SRCW  = 1;
  localparam int TL_SINKW = 1;
endpackage

// File: rtl/tl_rr_arbiter.sv
// tl_rr_arbiter: N-way round-robin arbiter that holds its grant while the downstream stalls
module tl_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             ready,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  logic [IDX_W-1:0] ptr_q, ptr_d, lidx_q, lidx_d, sel;
  logic             lock_q, lock_d, hs;
  // pick the first requester at or after the pointer, or replay the locked winner
  always_comb begin
    sel = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr_q) + k) % N]) sel = IDX_W'((int'(ptr_q) + k) % N);
    idx = lock_q ? lidx_q : sel;
    gnt = '0;
    for (int i = 0; i < N; i++) gnt[i] = (int'(idx) == i) && req[i];
    valid  = |gnt;
    hs     = valid && ready;
    ptr_d  = hs ? ((int'(idx) == N - 1) ? '0 : idx + IDX_W'(1)) : ptr_q;
    lock_d = valid && !ready;
    lidx_d = idx;
  end
  // pointer and lock state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr_q  <= '0;
      lidx_q <= '0;
      lock_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      lidx_q <= lidx_d;
      lock_q <= lock_d;
    end
endmodule

// File: rtl/tl_xbar_nm.sv
// tl_xbar_nm: N-master to 1-slave TL-UL crossbar; TL_XBAR_REG_SLICE_EN adds a 2-entry A-channel slice
module tl_xbar_nm
  import tl_pkg::*;
#(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_WIDTH      = TL_AW,
  parameter int DATA_WIDTH      = TL_DW,
  parameter int SIZE_WIDTH      = TL_SZW,
  parameter int OPCODE_WIDTH    = TL_OPW,
  parameter int PARAM_WIDTH     = TL_PW,
  parameter int SRC_WIDTH       = TL_SRCW,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int OSRC_W = IDX_W + SRC_WIDTH,
  localparam int MW     = DATA_WIDTH / 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_MASTERS-1:0]              m_a_valid,
  output logic [N_MASTERS-1:0]              m_a_ready,
  input  logic [N_MASTERS*OPCODE_WIDTH-1:0] m_a_opcode,
  input  logic [N_MASTERS*PARAM_WIDTH-1:0]  m_a_param,
  input  logic [N_MASTERS*SIZE_WIDTH-1:0]   m_a_size,
  input  logic [N_MASTERS*SRC_WIDTH-1:0]    m_a_source,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]   m_a_address,
  input  logic [N_MASTERS*MW-1:0]           m_a_mask,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]   m_a_data,
  output logic [N_MASTERS-1:0]              m_d_valid,
  input  logic [N_MASTERS-1:0]              m_d_ready,
  output logic [N_MASTERS*OPCODE_WIDTH-1:0] m_d_opcode,
  output logic [N_MASTERS*PARAM_WIDTH-1:0]  m_d_param,
  output logic [N_MASTERS*SIZE_WIDTH-1:0]   m_d_size,
  output logic [N_MASTERS*SRC_WIDTH-1:0]    m_d_source,
  output logic [N_MASTERS*TL_SINKW-1:0]     m_d_sink,
  output logic [N_MASTERS*DATA_WIDTH-1:0]   m_d_data,
  output logic [N_MASTERS-1:0]              m_d_error,
  output logic                              a_valid_out,
  input  logic                              a_ready_out,
  output logic [OPCODE_WIDTH-1:0]           a_opcode_out,
  output logic [PARAM_WIDTH-1:0]            a_param_out,
  output logic [SIZE_WIDTH-1:0]             a_size_out,
  output logic [OSRC_W-1:0]                 a_source_out,
  output logic [ADDR_WIDTH-1:0]             a_address_out,
  output logic [MW-1:0]                     a_mask_out,
  output logic [DATA_WIDTH-1:0]             a_data_out,
  input  logic                              d_valid_in,
  output logic                              d_ready_in,
  input  logic [OPCODE_WIDTH-1:0]           d_opcode_in,
  input  logic [PARAM_WIDTH-1:0]            d_param_in,
  input  logic [SIZE_WIDTH-1:0]             d_size_in,
  input  logic [OSRC_W-1:0]                 d_source_in,
  input  logic [TL_SINKW-1:0]               d_sink_in,
  input  logic [DATA_WIDTH-1:0]             d_data_in,
  input  logic                              d_error_in,
  output logic                              err_unmapped
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW    = OPCODE_WIDTH + PARAM_WIDTH + SIZE_WIDTH + OSRC_W + ADDR_WIDTH + MW + DATA_WIDTH;
  logic [N_MASTERS-1:0] elig, gnt, inc, dec, uflow, dsel;
  logic [IDX_W-1:0]     idx, d_idx;
  logic                 gnt_any, arb_ready, a_hs, d_hs, unmapped, err_q, err_d;
  logic [PW-1:0]        pl, a_pl_out;

  tl_rr_arbiter #(.N(N_MASTERS), .IDX_W(IDX_W)) u_arb (
    .clk(clk), .reset(reset), .req(elig), .ready(arb_ready),
    .gnt(gnt), .idx(idx), .valid(gnt_any)
  );

  // A payload of the granted master, tagged with its index in the upper source bits
  always_comb begin
    pl = '0;
    for (int i = 0; i < N_MASTERS; i++)
      if (gnt[i])
        pl = {m_a_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH], m_a_param[i*PARAM_WIDTH +: PARAM_WIDTH],
              m_a_size[i*SIZE_WIDTH +: SIZE_WIDTH], idx, m_a_source[i*SRC_WIDTH +: SRC_WIDTH],
              m_a_address[i*ADDR_WIDTH +: ADDR_WIDTH], m_a_mask[i*MW +: MW],
              m_a_data[i*DATA_WIDTH +: DATA_WIDTH]};
  end

`ifdef TL_XBAR_REG_SLICE_EN
  logic [PW-1:0] mem_q [2], mem_d [2];
  logic          wp_q, wp_d, rp_q, rp_d, deq;
  logic [1:0]    sl_q, sl_d;
  assign arb_ready   = sl_q != 2'd2;
  assign a_valid_out = sl_q != 2'd0;
  assign a_pl_out    = mem_q[rp_q];
  assign deq         = a_valid_out && a_ready_out;
  // skid FIFO: arbiter winners enqueue, slave handshakes dequeue
  always_comb begin
    mem_d = mem_q;
    if (a_hs) mem_d[wp_q] = pl;
    wp_d = wp_q ^ a_hs;
    rp_d = rp_q ^ deq;
    sl_d = sl_q + {1'b0, a_hs} - {1'b0, deq};
  end
  // slice storage and pointers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem_q <= '{default: '0};
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      sl_q  <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      sl_q  <= sl_d;
    end
`else
  assign arb_ready   = a_ready_out;
  assign a_valid_out = gnt_any;
  assign a_pl_out    = pl;
`endif

  assign a_hs      = gnt_any && arb_ready;
  assign m_a_ready = gnt & {N_MASTERS{arb_ready}};
  assign {a_opcode_out, a_param_out, a_size_out, a_source_out, a_address_out, a_mask_out, a_data_out} = a_pl_out;

  assign d_idx      = d_source_in[OSRC_W-1:SRC_WIDTH];
  assign unmapped   = ~|dsel;
  assign m_d_valid  = dsel & {N_MASTERS{d_valid_in}};
  assign d_ready_in = unmapped | |(dsel & m_d_ready);
  assign d_hs       = d_valid_in && d_ready_in;
  assign m_d_opcode = {N_MASTERS{d_opcode_in}};
  assign m_d_param  = {N_MASTERS{d_param_in}};
  assign m_d_size   = {N_MASTERS{d_size_in}};
  assign m_d_source = {N_MASTERS{d_source_in[SRC_WIDTH-1:0]}};
  assign m_d_sink   = {N_MASTERS{d_sink_in}};
  assign m_d_data   = {N_MASTERS{d_data_in}};
  assign m_d_error  = {N_MASTERS{d_error_in}};

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign dsel[i]  = d_idx == IDX_W'(i);
    assign elig[i]  = m_a_valid[i] && cnt_q < CNT_W'(MAX_OUTSTANDING);
    assign inc[i]   = a_hs && gnt[i];
    assign dec[i]   = d_hs && dsel[i] && cnt_q != '0;
    assign uflow[i] = d_hs && dsel[i] && cnt_q == '0;
    // in-flight count per master; a response with nothing outstanding is not subtracted
    always_comb cnt_d = cnt_q + CNT_W'(inc[i]) - CNT_W'(dec[i]);
    // outstanding counter register
    always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
  end

  // sticky flag for responses that match no master or no outstanding request
  always_comb err_d = err_q | (d_valid_in && unmapped) | |uflow;
  // error flag register
  always_ff @(posedge clk or posedge reset)
    if (reset) err_q <= 1'b0;
    else err_q <= err_d;
  assign err_unmapped = err_q;
endmodule

// File: tb/tb_tl_xbar_nm.sv
// tb_tl_xbar_nm: directed table-driven bench for tl_xbar_nm with a 2-master and a 3-master instance
module tb_tl_xbar_nm;
  import tl_pkg::*;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;

  logic [1:0]  mav, mar, mdv, mdr, masrc, mdsrc, mdsink, mderr;
  logic [5:0]  maop, mapar, masz, mdop, mdpar, mdsz;
  logic [63:0] maaddr, madata, mddata;
  logic [7:0]  mamask;
  logic        av, ar, dv, dr, dsink, derr, err;
  logic [2:0]  aop, apar, asz, dop, dpar, dsz;
  logic [1:0]  asrc, dsrc;
  logic [31:0] aaddr, adata, ddata;
  logic [3:0]  amask;

  logic [2:0]  t_mav, t_mar, t_mdv, t_mdr, t_masrc, t_mdsrc, t_mdsink, t_mderr;
  logic [8:0]  t_maop, t_mapar, t_masz, t_mdop, t_mdpar, t_mdsz;
  logic [95:0] t_maaddr, t_madata, t_mddata;
  logic [11:0] t_mamask;
  logic        t_av, t_ar, t_dv, t_dr, t_dsink, t_derr, t_err;
  logic [2:0]  t_aop, t_apar, t_asz, t_dop, t_dpar, t_dsz, t_asrc, t_dsrc;
  logic [31:0] t_aaddr, t_adata, t_ddata;
  logic [3:0]  t_amask;

  tl_xbar_nm #(.N_MASTERS(2), .MAX_OUTSTANDING(2)) u2 (
    .clk(clk), .reset(rst), .m_a_valid(mav), .m_a_ready(mar), .m_a_opcode(maop), .m_a_param(mapar),
    .m_a_size(masz), .m_a_source(masrc), .m_a_address(maaddr), .m_a_mask(mamask), .m_a_data(madata),
    .m_d_valid(mdv), .m_d_ready(mdr), .m_d_opcode(mdop), .m_d_param(mdpar), .m_d_size(mdsz),
    .m_d_source(mdsrc), .m_d_sink(mdsink), .m_d_data(mddata), .m_d_error(mderr),
    .a_valid_out(av), .a_ready_out(ar), .a_opcode_out(aop), .a_param_out(apar), .a_size_out(asz),
    .a_source_out(asrc), .a_address_out(aaddr), .a_mask_out(amask), .a_data_out(adata),
    .d_valid_in(dv), .d_ready_in(dr), .d_opcode_in(dop), .d_param_in(dpar), .d_size_in(dsz),
    .d_source_in(dsrc), .d_sink_in(dsink), .d_data_in(ddata), .d_error_in(derr), .err_unmapped(err)
  );

  tl_xbar_nm #(.N_MASTERS(3), .MAX_OUTSTANDING(4)) u3 (
    .clk(clk), .reset(rst), .m_a_valid(t_mav), .m_a_ready(t_mar), .m_a_opcode(t_maop), .m_a_param(t_mapar),
    .m_a_size(t_masz), .m_a_source(t_masrc), .m_a_address(t_maaddr), .m_a_mask(t_mamask), .m_a_data(t_madata),
    .m_d_valid(t_mdv), .m_d_ready(t_mdr), .m_d_opcode(t_mdop), .m_d_param(t_mdpar), .m_d_size(t_mdsz),
    .m_d_source(t_mdsrc), .m_d_sink(t_mdsink), .m_d_data(t_mddata), .m_d_error(t_mderr),
    .a_valid_out(t_av), .a_ready_out(t_ar), .a_opcode_out(t_aop), .a_param_out(t_apar), .a_size_out(t_asz),
    .a_source_out(t_asrc), .a_address_out(t_aaddr), .a_mask_out(t_amask), .a_data_out(t_adata),
    .d_valid_in(t_dv), .d_ready_in(t_dr), .d_opcode_in(t_dop), .d_param_in(t_dpar), .d_size_in(t_dsz),
    .d_source_in(t_dsrc), .d_sink_in(t_dsink), .d_data_in(t_ddata), .d_error_in(t_derr), .err_unmapped(t_err)
  );

  typedef struct packed {
    logic [1:0] mav;
    logic       ar;
    logic       dv;
    logic [1:0] dsrc;
    logic [1:0] mdr;
    logic       e_av;
    logic [1:0] e_asrc;
    logic [1:0] e_mar;
    logic [1:0] e_mdv;
    logic       e_dr;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic drv(input logic [1:0] v, input logic r, input logic d, input logic [1:0] s, input logic [1:0] m);
    mav = v; ar = r; dv = d; dsrc = s; mdr = m;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drv(2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    maop = {TL_GET, TL_PUT_FULL_DATA}; mapar = '0; masz = {3'd2, 3'd2}; masrc = 2'b01;
    maaddr = {32'hB000_0001, 32'hA000_0000}; mamask = 8'hFF; madata = {32'h1111_1111, 32'h2222_2222};
    dop = TL_ACCESS_ACK_DATA; dpar = '0; dsz = 3'd2; dsink = 1'b0; ddata = 32'hDEAD_BEEF; derr = 1'b0;
    t_mav = '0; t_ar = 1'b0; t_dv = 1'b0; t_dsrc = '0; t_mdr = '0;
    t_maop = {TL_GET, TL_GET, TL_PUT_PARTIAL_DATA}; t_mapar = '0; t_masz = '0; t_masrc = '0;
    t_maaddr = '0; t_mamask = '0; t_madata = '0;
    t_dop = TL_ACCESS_ACK; t_dpar = '0; t_dsz = '0; t_dsink = 1'b0; t_ddata = '0; t_derr = 1'b0;
    //            mav ar dv dsrc mdr  av asrc mar mdv dr
    tbl[0]  = 16'b11_1_0_00_11_1_01_01_00_1;
    tbl[1]  = 16'b11_1_0_00_11_1_10_10_00_1;
    tbl[2]  = 16'b11_1_0_00_11_1_01_01_00_1;
    tbl[3]  = 16'b11_1_0_00_11_1_10_10_00_1;
    tbl[4]  = 16'b11_1_1_01_11_0_00_00_01_1;
    tbl[5]  = 16'b11_1_0_00_11_1_01_01_00_1;
    tbl[6]  = 16'b00_1_1_10_01_0_00_00_10_0;
    tbl[7]  = 16'b00_1_1_10_01_0_00_00_10_0;
    tbl[8]  = 16'b00_1_1_10_11_0_00_00_10_1;
    tbl[9]  = 16'b10_1_0_00_11_1_10_10_00_1;
    tbl[10] = 16'b11_1_1_01_11_0_00_00_01_1;
    tbl[11] = 16'b01_1_1_01_11_1_01_01_01_1;
    tbl[12] = 16'b01_1_0_00_11_1_01_01_00_1;
    tbl[13] = 16'b01_1_0_00_11_0_00_00_00_1;

    @(negedge clk);
    chk("reset a_valid", 64'(av), 64'd0);
    chk("reset m_a_ready", 64'(mar), 64'd0);
    chk("reset m_d_valid", 64'(mdv), 64'd0);
    chk("reset d_ready", 64'(dr), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drv(tbl[i].mav, tbl[i].ar, tbl[i].dv, tbl[i].dsrc, tbl[i].mdr);
      @(negedge clk);
      chk($sformatf("v%0d a_valid", i), 64'(av), 64'(tbl[i].e_av));
      if (tbl[i].e_av) chk($sformatf("v%0d a_source", i), 64'(asrc), 64'(tbl[i].e_asrc));
      chk($sformatf("v%0d m_a_ready", i), 64'(mar), 64'(tbl[i].e_mar));
      chk($sformatf("v%0d m_d_valid", i), 64'(mdv), 64'(tbl[i].e_mdv));
      chk($sformatf("v%0d d_ready", i), 64'(dr), 64'(tbl[i].e_dr));
      chk($sformatf("v%0d err", i), 64'(err), 64'd0);
      if (i == 4) begin
        chk("v4 m_d_source", 64'(mdsrc), 64'h3);
        chk("v4 m_d_data", mddata, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("v4 m_d_opcode", 64'(mdop), 64'(6'b001_001));
      end
      if (i == 6) chk("v6 m_d_source", 64'(mdsrc), 64'h0);
      if (i == 0) chk("v0 a_address", 64'(aaddr), 64'hA000_0000);
      if (i == 1) chk("v1 a_address", 64'(aaddr), 64'hB000_0001);
      tick();
    end

    rst = 1'b1;
    drv(2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    rst = 1'b0;

    drv(2'b01, 1'b1, 1'b0, 2'b00, 2'b11);
    @(negedge clk);
    chk("lock pre m_a_ready", 64'(mar), 64'h1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drv((c == 0) ? 2'b01 : 2'b11, 1'b0, 1'b0, 2'b00, 2'b11);
      @(negedge clk);
      chk($sformatf("lock c%0d a_source", c), 64'(asrc), 64'h1);
      chk($sformatf("lock c%0d a_address", c), 64'(aaddr), 64'hA000_0000);
      chk($sformatf("lock c%0d m_a_ready", c), 64'(mar), 64'h0);
      tick();
    end
    drv(2'b11, 1'b1, 1'b0, 2'b00, 2'b11);
    @(negedge clk);
    chk("lock release m_a_ready", 64'(mar), 64'h1);
    chk("lock release a_source", 64'(asrc), 64'h1);
    tick();
    drv(2'b11, 1'b0, 1'b0, 2'b00, 2'b11);
    @(negedge clk);
    chk("after lock a_source", 64'(asrc), 64'h2);
    chk("after lock a_address", 64'(aaddr), 64'hB000_0001);
    tick();

    rst = 1'b1;
    drv(2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    chk("midrst a_valid", 64'(av), 64'd0);
    chk("midrst m_a_ready", 64'(mar), 64'd0);
    chk("midrst m_d_valid", 64'(mdv), 64'd0);
    tick();
    rst = 1'b0;
    drv(2'b11, 1'b1, 1'b0, 2'b00, 2'b11);
    @(negedge clk);
    chk("post rst grant", 64'(asrc), 64'h1);
    tick();
    drv(2'b01, 1'b1, 1'b0, 2'b00, 2'b11);
    @(negedge clk);
    chk("post rst cnt cleared", 64'(mar), 64'h1);
    tick();

    drv(2'b00, 1'b0, 1'b1, 2'b10, 2'b11);
    @(negedge clk);
    chk("uflow d_ready", 64'(dr), 64'h1);
    chk("uflow err before", 64'(err), 64'h0);
    tick();
    drv(2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    chk("uflow err set", 64'(err), 64'h1);
    tick();
    @(negedge clk);
    chk("uflow err sticky", 64'(err), 64'h1);
    tick();

    t_ar = 1'b1;
    t_mav = 3'b111;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk($sformatf("n3 rr%0d a_source", g), 64'(t_asrc), 64'(g * 2));
      chk($sformatf("n3 rr%0d m_a_ready", g), 64'(t_mar), 64'(1 << g));
      tick();
    end
    t_mav = 3'b000; t_dv = 1'b1; t_dsrc = 3'b100; t_mdr = 3'b111;
    @(negedge clk);
    chk("n3 d idx2 m_d_valid", 64'(t_mdv), 64'h4);
    chk("n3 d idx2 d_ready", 64'(t_dr), 64'h1);
    tick();
    t_dsrc = 3'b110; t_mdr = 3'b000;
    @(negedge clk);
    chk("n3 unmapped d_ready", 64'(t_dr), 64'h1);
    chk("n3 unmapped m_d_valid", 64'(t_mdv), 64'h0);
    chk("n3 unmapped err before", 64'(t_err), 64'h0);
    tick();
    t_dv = 1'b0;
    @(negedge clk);
    chk("n3 unmapped err set", 64'(t_err), 64'h1);
    tick();
    @(negedge clk);
    chk("n3 unmapped err sticky", 64'(t_err), 64'h1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("n3 err cleared", 64'(t_err), 64'h0);
    chk("n2 err cleared", 64'(err), 64'h0);
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
